mls_scratchpad_responder: RTL
=============================

Name: mls_scratchpad_responder

Overview:
- Scratchpad-side responder for the matrix load/store FU request (done / ls_out / rd_out / imm_out / address / stride_out bundle).
- Accepts one matrix LD/ST request at a time and sequences DIM row transfers between data memory and the scratchpad matrix register file, each row at base + row*stride.
- Returns a one-cycle completion pulse tagged with rd and ls, which the MLS FU and scoreboard use to clear busy state.

Parameters:
- DIM, 4, rows per matrix tile; must be a power of 2 and ≥2.
- ROW_W, 64, bits per matrix row (DIM x 16-bit elements).
- WORD_W, 32, address and stride width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder idle and able to accept.
- req_ls  in  2  [1]=load, [0]=store, matching the ls_out encoding.
- req_rd  in  4  matrix register number.
- req_addr  in  WORD_W  base address; already includes imm.
- req_stride  in  WORD_W  byte stride between rows.
- mem_ren  out  1  memory row read request.
- mem_wen  out  1  memory row write request.
- mem_addr  out  WORD_W  row address.
- mem_wdata  out  ROW_W  store data.
- mem_rdata  in  ROW_W  load data; valid when mem_ack=1.
- mem_ack  in  1  memory completes the current request this cycle.
- sp_we  out  1  scratchpad row write.
- sp_waddr  out  4+log2(DIM)  {rd,row}.
- sp_wdata  out  ROW_W  row data.
- sp_re  out  1  scratchpad row read; sp_rdata is valid the next cycle.
- sp_raddr  out  4+log2(DIM)  {rd,row}.
- sp_rdata  in  ROW_W  read data.
- done  out  1  one-cycle completion pulse.
- done_rd  out  4  rd of the completed request.
- done_ls  out  2  ls of the completed request.
- done_err  out  1  completed request had an illegal ls.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, nRST=0):
  - State goes to IDLE and the row counter to 0.
  - All outputs are 0 except req_ready=1.
  - An in-flight request is dropped with no done pulse.
- IDLE:
  - req_ready=1.
  - On req_valid, capture rd, ls, stride, and row_addr=req_addr.
  - ls=2'b10 → LD_REQ; ls=2'b01 → ST_RD; ls=2'b00 or 2'b11 → DONE with done_err=1.
  - req_ready=0 in every other state; req_valid outside IDLE is ignored.
- LD_REQ:
  - mem_ren=1 and mem_addr=row_addr, held stable until mem_ack.
  - On mem_ack, latch mem_rdata and go to LD_WB.
- LD_WB:
  - sp_we=1 for exactly one cycle, sp_waddr={rd,row}, sp_wdata=latched data.
  - If row==DIM-1 → DONE; otherwise row+1, row_addr+=stride → LD_REQ.
- ST_RD:
  - sp_re=1 for one cycle with sp_raddr={rd,row}, then → ST_WR.
- ST_WR:
  - On entry, capture sp_rdata.
  - mem_wen=1, mem_addr=row_addr, mem_wdata=captured data, held until mem_ack.
  - On ack: if row==DIM-1 → DONE; otherwise row+1, row_addr+=stride → ST_RD.
- DONE:
  - done=1 for one cycle with done_rd/done_ls/done_err from the captured request, then → IDLE.
  - done_* are held at their last value when done=0.
- Address arithmetic: row_addr+=stride is modulo 2^WORD_W (wraps silently). stride=0 is legal: all rows use the same address.
- mem_ren and mem_wen are never asserted together. mem_ack outside LD_REQ/ST_WR is ignored.
- Latency with zero-wait memory (ack in the same cycle as the request), accept at cycle T: load and store each take 2 cycles per row, so done is at T+1+2*DIM (T+9 for DIM=4).
- Back-to-back: a new request can be accepted in the cycle after done (IDLE), not during DONE.

Test Plan:
- Load: rd=5, addr=0x1000, stride=0x40, zero-wait memory returning row i = {16{4'(i)}} → mem_addr 0x1000/0x1040/0x1080/0x10C0; sp_we at {5,0..3} with matching data; done at T+9 with done_rd=5, done_ls=2'b10.
- Store: rd=2, addr=0x2000, stride=0x10, scratchpad rows preloaded, mem_ack delayed 3 cycles per row → mem_wen/addr/wdata held stable during each wait; 4 writes at 0x2000..0x2030; one done pulse.
- Wrap: addr=0xFFFFFFF0, stride=0x10 → row addresses 0xFFFFFFF0, 0x0, 0x10, 0x20.
- Illegal ls=2'b11 → no mem or scratchpad activity; done=1 with done_err=1 at T+1.
- req_valid held high during a load → second request not accepted until IDLE; accepted the cycle after done.
- nRST asserted during row 2 of a load → outputs 0 immediately, no done; a fresh load after release completes normally.

Source files
------------

// File: rtl/mls_scratchpad_responder_if.sv
// Request, data-memory, scratchpad and completion signals of the matrix load/store responder.
// The slave modport is the responder's view; master is the surrounding FU/memory side.
interface mls_scratchpad_responder_if #(
  parameter int DIM    = 4,
  parameter int ROW_W  = 64,
  parameter int WORD_W = 32
);
  localparam int SPA_W = 4 + $clog2(DIM);

  // request from the MLS FU
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_ls;
  logic [3:0]        req_rd;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_stride;

  // data memory row port
  logic              mem_ren;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_wdata;
  logic [ROW_W-1:0]  mem_rdata;
  logic              mem_ack;

  // scratchpad matrix register file
  logic              sp_we;
  logic [SPA_W-1:0]  sp_waddr;
  logic [ROW_W-1:0]  sp_wdata;
  logic              sp_re;
  logic [SPA_W-1:0]  sp_raddr;
  logic [ROW_W-1:0]  sp_rdata;

  // completion
  logic              done;
  logic [3:0]        done_rd;
  logic [1:0]        done_ls;
  logic              done_err;
  logic              busy;

  modport slave (
    input  req_valid, req_ls, req_rd, req_addr, req_stride,
    input  mem_rdata, mem_ack, sp_rdata,
    output req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
    output sp_we, sp_waddr, sp_wdata, sp_re, sp_raddr,
    output done, done_rd, done_ls, done_err, busy
  );

  modport master (
    output req_valid, req_ls, req_rd, req_addr, req_stride,
    output mem_rdata, mem_ack, sp_rdata,
    input  req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
    input  sp_we, sp_waddr, sp_wdata, sp_re, sp_raddr,
    input  done, done_rd, done_ls, done_err, busy
  );
endinterface

// File: rtl/mls_scratchpad_responder.sv
// Scratchpad-side responder for matrix LD/ST: moves DIM rows between data memory and
// the scratchpad register file (row i at base + i*stride), then pulses done tagged with rd/ls.
module mls_scratchpad_responder #(
  parameter int DIM    = 4,
  parameter int ROW_W  = 64,
  parameter int WORD_W = 32
) (
  input logic                      CLK,
  input logic                      nRST,
  mls_scratchpad_responder_if.slave bus
);
  localparam int ROW_BITS = $clog2(DIM);
  localparam int SPA_W    = 4 + ROW_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    LD_WB  = 3'd2,
    ST_RD  = 3'd3,
    ST_WR  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [ROW_BITS-1:0] row;
  logic [WORD_W-1:0]   row_addr;
  logic [WORD_W-1:0]   stride;
  logic [3:0]          rd;
  logic [1:0]          ls;
  logic [ROW_W-1:0]    row_data;
  logic                wr_first;
  logic [3:0]          done_rd_q;
  logic [1:0]          done_ls_q;
  logic                done_err_q;

  logic accept;
  logic advance;
  logic last_row;

  assign last_row = (row == LAST_ROW);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          unique case (bus.req_ls)
            2'b10:   state_next = LD_REQ;
            2'b01:   state_next = ST_RD;
            default: state_next = DONE;
          endcase
        end
      end
      LD_REQ: if (bus.mem_ack) state_next = LD_WB;
      LD_WB: begin
        if (last_row) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = LD_REQ;
        end
      end
      ST_RD: state_next = ST_WR;
      ST_WR: begin
        if (bus.mem_ack) begin
          if (last_row) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = ST_RD;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      row        <= '0;
      row_addr   <= '0;
      stride     <= '0;
      rd         <= '0;
      ls         <= '0;
      row_data   <= '0;
      wr_first   <= 1'b0;
      done_rd_q  <= '0;
      done_ls_q  <= '0;
      done_err_q <= 1'b0;
    end else begin
      if (accept) begin
        rd       <= bus.req_rd;
        ls       <= bus.req_ls;
        stride   <= bus.req_stride;
        row_addr <= bus.req_addr;
        row      <= '0;
      end
      // address wraps modulo 2^WORD_W; stride 0 keeps every row at the base
      if (advance) begin
        row      <= row + 1'b1;
        row_addr <= row_addr + stride;
      end
      if (state == LD_REQ && bus.mem_ack) begin
        row_data <= bus.mem_rdata;
      end
      // sp_rdata is only valid in the first ST_WR cycle, so it is held locally from then on
      if (state == ST_WR && wr_first) begin
        row_data <= bus.sp_rdata;
      end
      wr_first <= (state == ST_RD);
      if (state_next == DONE && state != DONE) begin
        done_rd_q  <= accept ? bus.req_rd : rd;
        done_ls_q  <= accept ? bus.req_ls : ls;
        done_err_q <= accept;
      end
    end
  end

  logic              ld_wb;
  logic              st_rd;
  logic              st_wr;
  logic              ld_req;
  logic [SPA_W-1:0]  sp_row;
  logic [ROW_W-1:0]  wr_data;

  assign ld_req  = (state == LD_REQ);
  assign ld_wb   = (state == LD_WB);
  assign st_rd   = (state == ST_RD);
  assign st_wr   = (state == ST_WR);
  assign sp_row  = {rd, row};
  assign wr_data = wr_first ? bus.sp_rdata : row_data;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  assign bus.mem_ren   = ld_req;
  assign bus.mem_wen   = st_wr;
  assign bus.mem_addr  = (ld_req || st_wr) ? row_addr : '0;
  assign bus.mem_wdata = st_wr ? wr_data : '0;

  assign bus.sp_we     = ld_wb;
  assign bus.sp_waddr  = ld_wb ? sp_row : '0;
  assign bus.sp_wdata  = ld_wb ? row_data : '0;
  assign bus.sp_re     = st_rd;
  assign bus.sp_raddr  = st_rd ? sp_row : '0;

  assign bus.done      = (state == DONE);
  assign bus.done_rd   = done_rd_q;
  assign bus.done_ls   = done_ls_q;
  assign bus.done_err  = done_err_q;
endmodule
